// File: rtl/regfile_sb_if.sv
// regfile_sb_if
//   Bundles the register-file read, write-back and scoreboard signals so the
//   pipeline (master) and the register file (slave) share one port object.
//   Read ports are packed: port k uses rd_addr[k*ADDR_W +: ADDR_W],
//   rd_data[k*DATA_W +: DATA_W] and rd_busy[k].
//
//   Signals (master view):
//     rd_addr   out  NUM_RD*ADDR_W  read addresses
//     rd_data   in   NUM_RD*DATA_W  read data (combinational)
//     rd_busy   in   NUM_RD         per-port pending-producer flag
//     wr_en     out  1              write-back strobe
//     wr_addr   out  ADDR_W         write-back destination
//     wr_data   out  DATA_W         write-back data
//     sb_set    out  1              mark sb_addr pending
//     sb_addr   out  ADDR_W         register being marked
//     ready     in   1              clear sequence finished
//     any_busy  in   1              OR of all scoreboard bits
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     ready;
  logic                     any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input  rd_data, rd_busy, ready, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output rd_data, rd_busy, ready, any_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb
//   MIPS general-purpose register file with NUM_RD combinational read ports,
//   one write-back port, a hardwired zero register, a per-register pending
//   scoreboard and a post-reset clear sequencer. The storage array has no
//   reset so it can map onto distributed RAM; instead, after reset the
//   sequencer walks every entry and writes zero before raising ready.
//
//   Optional feature: define REGFILE_BYPASS_EN to forward same-cycle
//   write-back data (and busy release) to matching read ports.
//
//   Ports:
//     clk  in  core clock, all state updates on the rising edge
//     rst  in  synchronous active-high reset, restarts the clear sequence
//     bus  regfile_sb_if.slave  read/write/scoreboard bundle
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              any_busy_q;

  logic              run;
  logic              wb_valid;

  assign run      = (state == RUN);
  assign wb_valid = run && bus.wr_en && (bus.wr_addr != '0);

  // State and clear-counter register. Reset always lands in CLEAR with the
  // counter at entry 0, whether it arrives mid-clear or during normal use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic and array write-port steering. In CLEAR the array
  // port belongs to the sequencer and write-back is ignored; in RUN it
  // carries write-back, with writes to r0 dropped.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_we     = 1'b0;
    mem_waddr  = bus.wr_addr;
    mem_wdata  = bus.wr_data;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = '0;
        cnt_next  = cnt + ADDR_W'(1);
        if (cnt == {ADDR_W{1'b1}}) begin
          state_next = RUN;
        end
      end
      RUN: begin
        mem_we = wb_valid;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // Storage array: no reset on purpose so it infers as RAM; the clear
  // sequencer provides the zeroed contents.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Scoreboard next state. The set is applied after the clear so that a
  // same-address set and write-back leaves the bit pending: the newly
  // issued producer is younger than the one completing.
  always_comb begin
    busy_next = busy;
    if (!run) begin
      busy_next = '0;
    end else begin
      if (wb_valid) begin
        busy_next[bus.wr_addr] = 1'b0;
      end
      if (bus.sb_set && (bus.sb_addr != '0)) begin
        busy_next[bus.sb_addr] = 1'b1;
      end
    end
  end

  // Scoreboard register and the registered summary flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy       <= busy_next;
      any_busy_q <= |busy_next;
    end
  end

  assign bus.ready    = run;
  assign bus.any_busy = any_busy_q;

  // One independent combinational read port per k. Everything reads as
  // zero and not-busy until the clear sequence has finished.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy_bit;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data     = '0;
      busy_bit = 1'b0;
      if (run && (addr != '0)) begin
        data     = mem[addr];
        busy_bit = busy[addr];
`ifdef REGFILE_BYPASS_EN
        // Write-first forwarding; the busy flag drops with the completing
        // write unless a new producer claims the same register this cycle.
        if (wb_valid && (bus.wr_addr == addr)) begin
          data     = bus.wr_data;
          busy_bit = bus.sb_set && (bus.sb_addr == addr);
        end
`endif
      end
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[k]                  = busy_bit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   Self-checking bench for regfile_sb (DATA_W=32, ADDR_W=5, NUM_RD=2).
//   Expected values are pushed to exp_q when stimulus is driven and popped
//   when the DUT output is sampled. Inputs change and outputs are sampled
//   on the falling clock edge (or 1 time unit after the rising edge).
//   Honours REGFILE_BYPASS_EN for the same-cycle read expectations.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_v;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Hard time limit so a broken DUT can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  // Clear sequence from power-up: ready low for 31 edges, high on the 32nd,
  // then every entry reads zero on both ports.
  task automatic test_reset();
    logic [ADDR_W-1:0] a;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.sb_set  = 1'b0;
    bus.sb_addr = '0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0 || bus.any_busy !== 1'b0 || bus.rd_busy !== 2'b00 || bus.rd_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b any_busy=%b rd_busy=%b rd_data=%h, expected 0/0/00/0",
               bus.ready, bus.any_busy, bus.rd_busy, bus.rd_data);
    end
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      exp_q.push_back((i == DEPTH) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({31'd0, bus.ready} !== exp_v) begin
        errors++;
        $display("[TB] FAIL clear_ready edge %0d: got %b, expected %0d", i, bus.ready, exp_v);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      a = ADDR_W'(i);
      bus.rd_addr = {a, a};
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd_data[0 +: DATA_W] !== exp_v) begin
        errors++;
        $display("[TB] FAIL clear_read p0 r%0d: got %h, expected %h", i, bus.rd_data[0 +: DATA_W], exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd_data[DATA_W +: DATA_W] !== exp_v) begin
        errors++;
        $display("[TB] FAIL clear_read p1 r%0d: got %h, expected %h", i, bus.rd_data[DATA_W +: DATA_W], exp_v);
      end
    end
  endtask

  // Reset pulse at cnt = 10 restarts the full 32-cycle sequence.
  task automatic test_reset_mid_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      exp_q.push_back((i == DEPTH) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({31'd0, bus.ready} !== exp_v) begin
        errors++;
        $display("[TB] FAIL midclear_ready edge %0d: got %b, expected %0d", i, bus.ready, exp_v);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.rd_addr = {ADDR_W'(i), ADDR_W'(i)};
      exp_q.push_back('0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.rd_data[DATA_W +: DATA_W] !== exp_v) begin
        errors++;
        $display("[TB] FAIL midclear_read r%0d: got %h, expected %h", i, bus.rd_data[DATA_W +: DATA_W], exp_v);
      end
    end
  endtask

  // Write r5 and r0, then read both back; r5 on both ports at once too.
  task automatic test_write_read();
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd5;
    bus.wr_data = 32'hDEADBEEF;
    @(negedge clk);
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'h12345678;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.rd_addr = {5'd0, 5'd5};
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h00000000);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== exp_v) begin
      errors++;
      $display("[TB] FAIL write_read r5: got %h, expected %h", bus.rd_data[0 +: DATA_W], exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[DATA_W +: DATA_W] !== exp_v) begin
      errors++;
      $display("[TB] FAIL zero_reg r0: got %h, expected %h", bus.rd_data[DATA_W +: DATA_W], exp_v);
    end
    @(negedge clk);
    bus.rd_addr = {5'd5, 5'd5};
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[DATA_W +: DATA_W] !== exp_v || bus.rd_data[0 +: DATA_W] !== exp_v) begin
      errors++;
      $display("[TB] FAIL same_addr_ports: got %h/%h, expected %h",
               bus.rd_data[DATA_W +: DATA_W], bus.rd_data[0 +: DATA_W], exp_v);
    end
  endtask

  // Scoreboard set/hold/clear, same-address collision, split addresses, r0.
  task automatic test_scoreboard();
    @(negedge clk);
    bus.rd_addr = {5'd9, 5'd8};
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sb_set = 1'b0;
      exp_q.push_back(32'd1);
      exp_v = exp_q.pop_front();
      checks++;
      if ({31'd0, bus.rd_busy[0]} !== exp_v || {31'd0, bus.any_busy} !== exp_v) begin
        errors++;
        $display("[TB] FAIL sb_pending cycle %0d: rd_busy=%b any_busy=%b, expected %0d",
                 i, bus.rd_busy[0], bus.any_busy, exp_v);
      end
    end
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd8;
    bus.wr_data = 32'h11;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'd0);
`else
    exp_q.push_back(32'd1);
`endif
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.rd_busy[0]} !== exp_v) begin
      errors++;
      $display("[TB] FAIL sb_write_cycle_busy: got %b, expected %0d", bus.rd_busy[0], exp_v);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h11);
    exp_v = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.rd_busy[0]} !== exp_v || {31'd0, bus.any_busy} !== exp_v) begin
      errors++;
      $display("[TB] FAIL sb_released: rd_busy=%b any_busy=%b, expected %0d", bus.rd_busy[0], bus.any_busy, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== exp_v) begin
      errors++;
      $display("[TB] FAIL sb_write_data r8: got %h, expected %h", bus.rd_data[0 +: DATA_W], exp_v);
    end
    // Collision: set and write-back of r9 in the same cycle keeps it busy.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'h22;
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd9;
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.sb_set = 1'b0;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h22);
    exp_v = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.rd_busy[1]} !== exp_v || {31'd0, bus.any_busy} !== exp_v) begin
      errors++;
      $display("[TB] FAIL sb_collision: rd_busy=%b any_busy=%b, expected %0d", bus.rd_busy[1], bus.any_busy, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[DATA_W +: DATA_W] !== exp_v) begin
      errors++;
      $display("[TB] FAIL sb_collision_data r9: got %h, expected %h", bus.rd_data[DATA_W +: DATA_W], exp_v);
    end
    // Different addresses: release r9 while marking r10; both take effect.
    bus.rd_addr = {5'd10, 5'd9};
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'h33;
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd10;
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.sb_set = 1'b0;
    exp_q.push_back(32'b10);
    exp_v = exp_q.pop_front();
    checks++;
    if ({30'd0, bus.rd_busy} !== exp_v) begin
      errors++;
      $display("[TB] FAIL sb_split_addr: got %b, expected %b", bus.rd_busy, exp_v[1:0]);
    end
    // Release r10, then marking r0 must be ignored.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd10;
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd0;
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.sb_set = 1'b0;
    bus.rd_addr = {5'd0, 5'd10};
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.any_busy} !== exp_v || {30'd0, bus.rd_busy} !== exp_v) begin
      errors++;
      $display("[TB] FAIL sb_r0_ignored: any_busy=%b rd_busy=%b, expected 0", bus.any_busy, bus.rd_busy);
    end
  endtask

  // Same-cycle write and read of r3, and a same-cycle write to r0.
  task automatic test_bypass();
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 32'h00000001;
    @(negedge clk);
    bus.wr_data = 32'hA5A5A5A5;
    bus.rd_addr = {5'd3, 5'd0};
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hA5A5A5A5);
`else
    exp_q.push_back(32'h00000001);
`endif
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[DATA_W +: DATA_W] !== exp_v) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got %h, expected %h", bus.rd_data[DATA_W +: DATA_W], exp_v);
    end
    @(negedge clk);
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'hFFFFFFFF;
    exp_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[DATA_W +: DATA_W] !== exp_v) begin
      errors++;
      $display("[TB] FAIL bypass_next_cycle: got %h, expected %h", bus.rd_data[DATA_W +: DATA_W], exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== exp_v) begin
      errors++;
      $display("[TB] FAIL bypass_r0: got %h, expected %h", bus.rd_data[0 +: DATA_W], exp_v);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Reset during RUN wipes written data and pending bits.
  task automatic test_reset_in_run();
    @(negedge clk);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd12;
    @(negedge clk);
    bus.sb_set = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.ready} !== exp_v || {31'd0, bus.any_busy} !== exp_v) begin
      errors++;
      $display("[TB] FAIL run_reset_state: ready=%b any_busy=%b, expected 0", bus.ready, bus.any_busy);
    end
    repeat (DEPTH) @(posedge clk);
    @(negedge clk);
    bus.rd_addr = {5'd12, 5'd5};
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({31'd0, bus.ready} !== exp_v) begin
      errors++;
      $display("[TB] FAIL run_reset_ready: got %b, expected %0d", bus.ready, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (bus.rd_data[0 +: DATA_W] !== exp_v || {30'd0, bus.rd_busy} !== exp_v) begin
      errors++;
      $display("[TB] FAIL run_reset_cleared: r5=%h rd_busy=%b, expected 0/00", bus.rd_data[0 +: DATA_W], bus.rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_clear();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
